mem_arbiter_hs: RTL and testbench
=================================

// Module: mem_arbiter_hs
// PURPOSE
// - Next-generation memory interface for TRV-32I: one single-ported word RAM shared by the fetch and load/store ports.
// - Each port uses a req/gnt/rvalid handshake; only one access is outstanding at a time.
// - Response latency is configurable; RV32I byte/half/word lane steering and sign extension are done in-block.
// - Sits between the core pipeline (IF and MEM stages) and the backing store.
// PARAMETERS
// - B_WIDTH   32    data/address width; only 32 is supported
// - MEM_SIZE  1024  RAM depth in 32-bit words; must be a power of 2
// - LATENCY   1     cycles from grant cycle to rvalid cycle; must be >=1
// PORTS
// - clk        in   1        clock, rising edge
// - rst        in   1        reset, asynchronous, active-high
// - if_req     in   1        fetch request; held until granted
// - if_addr    in   B_WIDTH  fetch byte address; bits [1:0] ignored
// - if_gnt     out  1        fetch request accepted this cycle
// - if_rvalid  out  1        one-cycle pulse; if_rdata valid
// - if_rdata   out  32       fetched instruction word
// - d_req      in   1        data request; held until granted
// - d_we       in   1        1=store, 0=load
// - d_size     in   2        00=byte, 01=half, 10=word; 11 is treated as word
// - d_unsigned in   1        zero-extend the load (LBU/LHU)
// - d_addr     in   B_WIDTH  data byte address
// - d_wdata    in   B_WIDTH  store data, right-aligned
// - d_gnt      out  1        data request accepted this cycle
// - d_rvalid   out  1        one-cycle pulse: load data or store acknowledge
// - d_rdata    out  B_WIDTH  extended load data; 0 on store
// - d_err      out  1        qualifies d_rvalid: misaligned access
// BEHAVIOUR
// - Reset: FSM to IDLE, starvation counter to 0, every output to 0. RAM contents are not reset.
// - FSM states: IDLE, BUSY.
//   - IDLE->BUSY on any grant.
//   - BUSY counts LATENCY-1 cycles, then drives rvalid for 1 cycle and returns to IDLE.
//   - With LATENCY=1, BUSY lasts exactly one cycle and is also the rvalid cycle.
// - Grants are combinational, and are issued only in IDLE or in the rvalid cycle. A new grant in the rvalid cycle gives back-to-back throughput of 1 access per LATENCY cycles.
// - Request fields are captured on the grant edge.
// - Arbitration is data-first with a starvation guard.
//   - Counter starv increments on each data grant taken while if_req=1.
//   - If starv==2 and if_req=1, fetch wins and starv clears.
//   - starv also clears on any fetch grant.
// - Word index = addr[$clog2(MEM_SIZE)+1:2]. Higher address bits are ignored, so accesses wrap modulo MEM_SIZE words.
// - Store: byte enables come from d_size and d_addr[1:0] (SB 0001<<a, SH 0011<<a, SW 1111). d_wdata is replicated across lanes.
// - The RAM write commits on the grant edge. Reset after the grant does not undo it, but suppresses the pending rvalid.
// - Load: selected lane shifted to bit 0, then sign- or zero-extended per d_unsigned.
// - Read data is sampled from the RAM at the grant edge and held in a response register until rvalid.
// - Simultaneous if_req and d_req: exactly one gnt is high in any cycle, never both.
// - A requester whose req drops before gnt is simply not served; there is no error.
// CONFIGURATION
// - MEM_MISALIGN_TRAP_EN defined:
//   - A half access with addr[0]=1, or a word access with addr[1:0]!=0, is still granted and timed normally.
//   - No RAM write occurs; the response has d_rvalid=1, d_err=1, d_rdata=0.
// - MEM_MISALIGN_TRAP_EN undefined:
//   - Misaligned addresses are aligned down to the access size; d_err is tied to 0.
// TESTING
// - Reset mid-BUSY: LATENCY=3, load granted, rst at cycle 2 -> no d_rvalid, all outputs 0.
// - SW 0xDEADBEEF @0x10, then LB @0x13 / LBU @0x13 / LH @0x12 -> d_rdata 0xFFFFFFDE / 0x000000DE / 0xFFFFDEAD.
// - SB 0x5A @0x21 over word 0 -> word 0x00005A00; LW @0x20 returns 0x00005A00, d_err=0.
// - LATENCY=2: if_req only, 4 fetches -> if_rvalid 2 cycles after each if_gnt, grants every 2 cycles.
// - if_req and d_req held high continuously -> grant order D,D,I,D,D,I; never both gnts in one cycle.
// - LW @0x4002 with MEM_SIZE=1024:
//   - macro defined -> d_err=1, d_rdata=0, RAM unchanged.
//   - macro undefined -> reads word index 0 (wrap, aligned down), d_err=0.

Source files
------------

// File: rtl/mem_arbiter_hs.sv
// Shared single-port word RAM serving a fetch port and a load/store port over req/gnt/rvalid.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word data accesses answer with d_err instead of aligning down.
`timescale 1ns/1ps
module mem_arbiter_hs #(
    parameter int B_WIDTH  = 32,
    parameter int MEM_SIZE = 1024,
    parameter int LATENCY  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [B_WIDTH-1:0] if_addr,
    output logic               if_gnt,
    output logic               if_rvalid,
    output logic [31:0]        if_rdata,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [1:0]         d_size,
    input  logic               d_unsigned,
    input  logic [B_WIDTH-1:0] d_addr,
    input  logic [B_WIDTH-1:0] d_wdata,
    output logic               d_gnt,
    output logic               d_rvalid,
    output logic [B_WIDTH-1:0] d_rdata,
    output logic               d_err
);
    localparam int IW = $clog2(MEM_SIZE);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    starv_q, starv_d;

    logic [B_WIDTH-1:0] mem [MEM_SIZE];
    logic [B_WIDTH-1:0] word_q;
    logic               data_q, we_q, uns_q, err_q;
    logic [1:0]         size_q, off_q;

    logic               rvalid, grant_ok, fetch_first;
    logic [IW-1:0]      d_idx, if_idx;
    logic [1:0]         d_off;
    logic               d_wr, d_trap;
    logic [3:0]         d_be;
    logic [B_WIDTH-1:0] d_wrep;
    logic               unused_addr_bits;

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (size)
            2'b00:   load_ext = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   load_ext = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: load_ext = w;
        endcase
    endfunction

    assign d_idx  = d_addr[IW+1:2];
    assign if_idx = if_addr[IW+1:2];
    assign unused_addr_bits = ^{if_addr[B_WIDTH-1:IW+2], if_addr[1:0], d_addr[B_WIDTH-1:IW+2]};

    // Lane offset is aligned down to the access size; enables and replicated data follow it.
    always_comb begin
        d_off  = 2'b00;
        d_be   = 4'b1111;
        d_wrep = d_wdata;
        case (d_size)
            2'b00: begin
                d_off  = d_addr[1:0];
                d_be   = 4'b0001 << d_addr[1:0];
                d_wrep = {4{d_wdata[7:0]}};
            end
            2'b01: begin
                d_off  = {d_addr[1], 1'b0};
                d_be   = d_addr[1] ? 4'b1100 : 4'b0011;
                d_wrep = {2{d_wdata[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic d_mis;
    assign d_mis  = (d_size == 2'b01) ? d_addr[0] : (d_size[1] & (|d_addr[1:0]));
    assign d_trap = d_mis;
    assign d_wr   = d_gnt & d_we & ~d_mis;
`else
    assign d_trap = 1'b0;
    assign d_wr   = d_gnt & d_we;
`endif

    assign rvalid      = (state_q == BUSY) && (cnt_q == CW'(LATENCY - 1));
    assign grant_ok    = !rst && ((state_q == IDLE) || rvalid);
    assign fetch_first = if_req && (starv_q == 2'd2);

    always_comb begin
        if_gnt  = 1'b0;
        d_gnt   = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        starv_d = starv_q;
        if (grant_ok) begin
            if (d_req && !fetch_first) d_gnt = 1'b1;
            else if (if_req)           if_gnt = 1'b1;
        end
        if (d_gnt && if_req) starv_d = starv_q + 2'd1;
        if (if_gnt)          starv_d = 2'd0;
        if (state_q == BUSY) begin
            cnt_d = cnt_q + CW'(1);
            if (rvalid) state_d = IDLE;
        end
        if (if_gnt || d_gnt) begin
            state_d = BUSY;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            starv_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            starv_q <= starv_d;
        end
    end

    // RAM write and read sample both happen on the grant edge; the response is held until rvalid.
    always_ff @(posedge clk) begin
        if (d_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (d_be[i]) mem[d_idx][8*i +: 8] <= d_wrep[8*i +: 8];
            end
        end
        if (if_gnt || d_gnt) begin
            word_q <= mem[d_gnt ? d_idx : if_idx];
            data_q <= d_gnt;
            we_q   <= d_we;
            uns_q  <= d_unsigned;
            size_q <= d_size;
            off_q  <= d_off;
            err_q  <= d_trap;
        end
    end

    assign if_rvalid = rvalid & ~data_q;
    assign d_rvalid  = rvalid & data_q;
    assign if_rdata  = if_rvalid ? word_q : '0;
    assign d_rdata   = (d_rvalid && !we_q && !err_q) ? load_ext(word_q, off_q, size_q, uns_q) : '0;
    assign d_err     = d_rvalid & err_q;

endmodule

// File: tb/tb_mem_arbiter_hs.sv
// Self-checking bench for mem_arbiter_hs: directed lane/wrap/arbitration scenarios plus randomized
// traffic compared against a byte-addressed memory model.
`timescale 1ns/1ps
module tb_mem_arbiter_hs;
    localparam int LAT    = 2;
    localparam int MSZ    = 1024;
    localparam int NBYTES = MSZ * 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, if_req, if_gnt, if_rvalid, d_req, d_we, d_unsigned, d_gnt, d_rvalid, d_err;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic [1:0]  d_size;

    logic        r3_rst, r3_if_req, r3_if_gnt, r3_if_rvalid, r3_d_req, r3_d_we, r3_d_unsigned;
    logic        r3_d_gnt, r3_d_rvalid, r3_d_err;
    logic [31:0] r3_if_addr, r3_if_rdata, r3_d_addr, r3_d_wdata, r3_d_rdata;
    logic [1:0]  r3_d_size;

    mem_arbiter_hs #(.B_WIDTH(32), .MEM_SIZE(MSZ), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err)
    );

    mem_arbiter_hs #(.B_WIDTH(32), .MEM_SIZE(MSZ), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst(r3_rst),
        .if_req(r3_if_req), .if_addr(r3_if_addr), .if_gnt(r3_if_gnt), .if_rvalid(r3_if_rvalid),
        .if_rdata(r3_if_rdata),
        .d_req(r3_d_req), .d_we(r3_d_we), .d_size(r3_d_size), .d_unsigned(r3_d_unsigned),
        .d_addr(r3_d_addr), .d_wdata(r3_d_wdata), .d_gnt(r3_d_gnt), .d_rvalid(r3_d_rvalid),
        .d_rdata(r3_d_rdata), .d_err(r3_d_err)
    );

    int         n_pass  = 0;
    int         n_total = 0;
    int         m_starv;
    logic [7:0] mbytes [NBYTES];

    function automatic int nbytes_of(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic is_mis(input logic [1:0] sz, input logic [31:0] a);
        return (int'(a[1:0]) % nbytes_of(sz)) != 0;
    endfunction

    function automatic int base_of(input logic [1:0] sz, input logic [31:0] a);
        int b;
        b = int'(a % NBYTES);
        return b - (b % nbytes_of(sz));
    endfunction

    function automatic void m_load(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                                   output logic [31:0] v, output logic e);
        int n, base;
        logic [31:0] mask;
        n = nbytes_of(sz);
        base = base_of(sz, a);
        v = '0;
        e = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        if (is_mis(sz, a)) begin
            e = 1'b1;
            return;
        end
`endif
        for (int i = 0; i < n; i++) v = v | (32'(mbytes[base + i]) << (8 * i));
        if (n < 4) begin
            mask = (32'h1 << (8 * n)) - 32'h1;
            if (!uns && v[8*n-1]) v = v | ~mask;
        end
    endfunction

    function automatic void m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int base;
        base = base_of(sz, a);
`ifdef MEM_MISALIGN_TRAP_EN
        if (is_mis(sz, a)) return;
`endif
        for (int i = 0; i < nbytes_of(sz); i++) mbytes[base + i] = wd[8*i +: 8];
    endfunction

    function automatic logic [31:0] m_word(input logic [31:0] a);
        int base;
        base = base_of(2'b10, a);
        return {mbytes[base+3], mbytes[base+2], mbytes[base+1], mbytes[base]};
    endfunction

    function automatic logic st_err(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
        return is_mis(sz, a);
`else
        return 1'b0 & is_mis(sz, a);
`endif
    endfunction

    // Drives one data access; lat = cycles from grant to d_rvalid, -1 if no grant or no response.
    task automatic do_data(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                           input logic [31:0] wd, output int lat, output logic [31:0] rd, output logic er);
        logic got;
        lat = -1; rd = '0; er = 1'b0; got = 1'b0;
        @(negedge clk);
        d_req = 1'b1; d_we = we; d_size = sz; d_unsigned = uns; d_addr = a; d_wdata = wd;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (d_gnt) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (!got) begin d_req = 1'b0; return; end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            d_req = 1'b0;
            #1;
            if (d_rvalid) begin lat = k; rd = d_rdata; er = d_err; break; end
        end
    endtask

    task automatic do_fetch(input logic [31:0] a, output int lat, output logic [31:0] rd);
        logic got;
        lat = -1; rd = '0; got = 1'b0;
        @(negedge clk);
        if_req = 1'b1; if_addr = a;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (if_gnt) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (!got) begin if_req = 1'b0; return; end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if_req = 1'b0;
            #1;
            if (if_rvalid) begin lat = k; rd = if_rdata; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; r3_rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h4; d_req = 1'b1; d_we = 1'b1; d_size = 2'b10;
        d_unsigned = 1'b0; d_addr = 32'h0; d_wdata = 32'hFFFF_FFFF;
        r3_if_req = 1'b1; r3_if_addr = '0; r3_d_req = 1'b1; r3_d_we = 1'b0; r3_d_size = 2'b10;
        r3_d_unsigned = 1'b0; r3_d_addr = '0; r3_d_wdata = '0;
        @(negedge clk); #1;
        n_total++; if (if_gnt !== 1'b0) $display("FAIL reset_if_gnt: got %b want 0", if_gnt); else n_pass++;
        n_total++; if (d_gnt !== 1'b0) $display("FAIL reset_d_gnt: got %b want 0", d_gnt); else n_pass++;
        n_total++; if (if_rvalid !== 1'b0) $display("FAIL reset_if_rvalid: got %b want 0", if_rvalid); else n_pass++;
        n_total++; if (d_rvalid !== 1'b0) $display("FAIL reset_d_rvalid: got %b want 0", d_rvalid); else n_pass++;
        n_total++; if (if_rdata !== 32'h0) $display("FAIL reset_if_rdata: got %h want 0", if_rdata); else n_pass++;
        n_total++; if (d_rdata !== 32'h0) $display("FAIL reset_d_rdata: got %h want 0", d_rdata); else n_pass++;
        n_total++; if (d_err !== 1'b0) $display("FAIL reset_d_err: got %b want 0", d_err); else n_pass++;
        n_total++;
        if ({r3_if_gnt, r3_if_rvalid, r3_if_rdata, r3_d_gnt, r3_d_rvalid, r3_d_rdata, r3_d_err} !== '0)
            $display("FAIL reset_lat3_outputs: got nonzero want all 0");
        else n_pass++;
        @(negedge clk);
        rst = 1'b0; r3_rst = 1'b0;
        if_req = 1'b0; d_req = 1'b0; r3_if_req = 1'b0; r3_d_req = 1'b0;
        m_starv = 0;
    endtask

    task automatic test_lanes;
        int lat; logic [31:0] rd; logic er;
        do_data(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, rd, er);
        m_store(2'b10, 32'h10, 32'hDEAD_BEEF);
        n_total++; if (lat !== LAT || rd !== 32'h0 || er !== 1'b0)
            $display("FAIL sw_ack: got lat=%0d rdata=%h err=%b want lat=%0d rdata=0 err=0", lat, rd, er, LAT);
        else n_pass++;
        do_data(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, rd, er);
        n_total++; if (rd !== 32'hFFFF_FFDE) $display("FAIL lb_13: got %h want ffffffde", rd); else n_pass++;
        do_data(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, rd, er);
        n_total++; if (rd !== 32'h0000_00DE) $display("FAIL lbu_13: got %h want 000000de", rd); else n_pass++;
        do_data(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, rd, er);
        n_total++; if (rd !== 32'hFFFF_DEAD) $display("FAIL lh_12: got %h want ffffdead", rd); else n_pass++;
        do_data(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, er);
        m_store(2'b10, 32'h20, 32'h0);
        do_data(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_005A, lat, rd, er);
        m_store(2'b00, 32'h21, 32'h5A);
        do_data(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rd, er);
        n_total++; if (rd !== 32'h0000_5A00 || er !== 1'b0)
            $display("FAIL sb_merge: got %h err=%b want 00005a00 err=0", rd, er);
        else n_pass++;
    endtask

    task automatic test_misaligned_wrap;
        int lat; logic [31:0] rd, exp_rd; logic er, exp_er;
        do_data(1'b1, 2'b10, 1'b0, 32'h0, 32'h1234_5678, lat, rd, er);
        m_store(2'b10, 32'h0, 32'h1234_5678);
`ifdef MEM_MISALIGN_TRAP_EN
        exp_rd = 32'h0;          exp_er = 1'b1;
`else
        exp_rd = 32'h1234_5678;  exp_er = 1'b0;
`endif
        do_data(1'b0, 2'b10, 1'b0, 32'h4002, 32'h0, lat, rd, er);
        n_total++; if (rd !== exp_rd || er !== exp_er || lat !== LAT)
            $display("FAIL lw_4002: got %h err=%b lat=%0d want %h err=%b lat=%0d", rd, er, lat, exp_rd, exp_er, LAT);
        else n_pass++;
        do_data(1'b1, 2'b10, 1'b0, 32'h4002, 32'hAAAA_AAAA, lat, rd, er);
        m_store(2'b10, 32'h4002, 32'hAAAA_AAAA);
        n_total++; if (rd !== 32'h0 || er !== exp_er)
            $display("FAIL sw_4002_ack: got %h err=%b want 0 err=%b", rd, er, exp_er);
        else n_pass++;
        do_data(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, lat, rd, er);
        exp_rd = m_word(32'h0);
        n_total++; if (rd !== exp_rd) $display("FAIL word0_after_sw_4002: got %h want %h", rd, exp_rd); else n_pass++;
    endtask

    task automatic test_random;
        int lat; logic [31:0] rd, a, wd, exp_rd; logic er, exp_er, we, uns; logic [1:0] sz;
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            do_data(1'b1, 2'b10, 1'b0, 32'(w * 4), wd, lat, rd, er);
            m_store(2'b10, 32'(w * 4), wd);
            n_total++; if (lat !== LAT) $display("FAIL init_sw_%0d: got lat=%0d want %0d", w, lat, LAT); else n_pass++;
        end
        for (int t = 0; t < 60; t++) begin
            a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) begin
                exp_rd = m_word(a);
                do_fetch(a, lat, rd);
                n_total++; if (lat !== LAT || rd !== exp_rd)
                    $display("FAIL rnd_fetch_%0d: addr=%h got %h lat=%0d want %h lat=%0d", t, a, rd, lat, exp_rd, LAT);
                else n_pass++;
            end else begin
                we = 1'($urandom); sz = 2'($urandom); uns = 1'($urandom); wd = $urandom;
                if (we) begin exp_rd = '0; exp_er = st_err(sz, a); end
                else m_load(sz, uns, a, exp_rd, exp_er);
                do_data(we, sz, uns, a, wd, lat, rd, er);
                if (we) m_store(sz, a, wd);
                n_total++; if (lat !== LAT || rd !== exp_rd || er !== exp_er)
                    $display("FAIL rnd_data_%0d: we=%b sz=%0d addr=%h got %h err=%b lat=%0d want %h err=%b lat=%0d",
                             t, we, sz, a, rd, er, lat, exp_rd, exp_er, LAT);
                else n_pass++;
            end
        end
    endtask

    task automatic test_fetch_stream;
        int ngnt, nrv; int gq [4]; logic [31:0] eq [4]; logic g;
        ngnt = 0; nrv = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h20;
        for (int cyc = 0; cyc < 30 && nrv < 4; cyc++) begin
            #1;
            if (if_rvalid) begin
                n_total++;
                if (nrv >= ngnt) $display("FAIL stream_spurious_rvalid: got rvalid with no pending fetch");
                else if (cyc - gq[nrv] != LAT || if_rdata !== eq[nrv])
                    $display("FAIL stream_rv_%0d: got delay=%0d data=%h want delay=%0d data=%h",
                             nrv, cyc - gq[nrv], if_rdata, LAT, eq[nrv]);
                else n_pass++;
                nrv++;
            end
            g = if_gnt;
            if (if_gnt) begin
                n_total++;
                if (ngnt >= 4) $display("FAIL stream_extra_gnt: got grant %0d want 4 grants", ngnt + 1);
                else if (ngnt > 0 && cyc - gq[ngnt-1] != LAT)
                    $display("FAIL stream_gnt_spacing: got %0d want %0d", cyc - gq[ngnt-1], LAT);
                else n_pass++;
                if (ngnt < 4) begin gq[ngnt] = cyc; eq[ngnt] = m_word(if_addr); end
                ngnt++;
            end
            @(negedge clk);
            if (g) begin
                if (ngnt >= 4) if_req = 1'b0;
                else if_addr = if_addr + 32'd4;
            end
        end
        if_req = 1'b0;
        n_total++; if (nrv !== 4) $display("FAIL stream_count: got %0d responses want 4", nrv); else n_pass++;
    endtask

    task automatic test_arbitration;
        int ng, last; logic exp_d;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        m_starv = 0;
        if_req = 1'b1; if_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_unsigned = 1'b0; d_addr = 32'h10;
        ng = 0; last = -1;
        for (int cyc = 0; cyc < 40 && ng < 6; cyc++) begin
            #1;
            n_total++; if (if_gnt && d_gnt) $display("FAIL arb_both_gnt: got both gnts in cycle %0d", cyc); else n_pass++;
            if (if_gnt || d_gnt) begin
                exp_d = (m_starv != 2);
                m_starv = exp_d ? m_starv + 1 : 0;
                n_total++; if (d_gnt !== exp_d)
                    $display("FAIL arb_order_%0d: got d_gnt=%b want %b", ng, d_gnt, exp_d);
                else n_pass++;
                if (last >= 0) begin
                    n_total++; if (cyc - last != LAT)
                        $display("FAIL arb_spacing_%0d: got %0d want %0d", ng, cyc - last, LAT);
                    else n_pass++;
                end
                last = cyc;
                ng++;
            end
            @(negedge clk);
        end
        if_req = 1'b0; d_req = 1'b0;
        n_total++; if (ng != 6) $display("FAIL arb_grant_count: got %0d want 6", ng); else n_pass++;
        repeat (LAT + 1) @(negedge clk);
    endtask

    task automatic test_reset_mid_busy;
        int seen;
        @(negedge clk);
        r3_d_req = 1'b1; r3_d_we = 1'b0; r3_d_size = 2'b10; r3_d_addr = 32'h8;
        #1;
        n_total++; if (r3_d_gnt !== 1'b1) $display("FAIL midrst_gnt: got %b want 1", r3_d_gnt); else n_pass++;
        @(negedge clk);
        r3_d_req = 1'b0;
        #1;
        n_total++; if (r3_d_rvalid !== 1'b0) $display("FAIL midrst_early_rvalid: got %b want 0", r3_d_rvalid); else n_pass++;
        @(negedge clk);
        r3_rst = 1'b1;
        #1;
        n_total++;
        if ({r3_if_gnt, r3_if_rvalid, r3_if_rdata, r3_d_gnt, r3_d_rvalid, r3_d_rdata, r3_d_err} !== '0)
            $display("FAIL midrst_outputs: got nonzero want all 0");
        else n_pass++;
        seen = 0;
        @(negedge clk);
        r3_rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (r3_d_rvalid) seen++;
            @(negedge clk);
        end
        n_total++; if (seen != 0) $display("FAIL midrst_suppressed: got %0d rvalid pulses want 0", seen); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_lanes();
        test_misaligned_wrap();
        test_random();
        test_fetch_stream();
        test_arbitration();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
